// File: rtl/dpi_seq_pkg.sv
// Shared types and defaults for the DPI stream sequencer and its stream table.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dpi_seq_pkg;

  localparam int NUM_REGEX_DEF = 16;
  localparam int SID_W_DEF     = 6;
  localparam int LOAD_GAP_DEF  = 2;
  localparam int DRAIN_CYC_DEF = 3;

  // Width of the shared gap/drain down-counter; LOAD_GAP and DRAIN_CYC must fit.
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_GAP,
    ST_STREAM,
    ST_DRAIN,
    ST_EOP,
    ST_RESULT
  } seq_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dpi_stream_table.sv
// Per-stream table: one "seen" flag and one regex enable mask per stream id.
// Latency: combinational read, updates take effect the cycle after the write.
// Backpressure: none; every set/clear/cfg request is applied unconditionally.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset (seen=0, masks=all 1s)
//   rd_sid              lookup stream id
//   rd_seen, rd_mask    combinational lookup result for rd_sid
//   set_seen            mark rd_sid as seen
//   clear_all           forget every seen flag (set_seen on the same cycle still wins for rd_sid)
//   cfg_we/sid/mask     write the enable mask of cfg_sid
module dpi_stream_table
  import dpi_seq_pkg::*;
#(
  parameter int SID_W     = SID_W_DEF,
  parameter int NUM_REGEX = NUM_REGEX_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SID_W-1:0]     rd_sid,
  output logic                 rd_seen,
  output logic [NUM_REGEX-1:0] rd_mask,
  input  logic                 set_seen,
  input  logic                 clear_all,
  input  logic                 cfg_we,
  input  logic [SID_W-1:0]     cfg_sid,
  input  logic [NUM_REGEX-1:0] cfg_mask
);

  localparam int DEPTH = 1 << SID_W;

  logic [DEPTH-1:0]     seen_q, seen_d;
  logic [NUM_REGEX-1:0] mask_q [DEPTH];
  logic [NUM_REGEX-1:0] mask_d [DEPTH];

  assign rd_seen = seen_q[rd_sid];
  assign rd_mask = mask_q[rd_sid];

  always_comb begin
    seen_d = clear_all ? '0 : seen_q;
    // The stream being loaded stays marked even when a clear lands on the same cycle.
    if (set_seen) begin
      seen_d[rd_sid] = 1'b1;
    end
    for (int i = 0; i < DEPTH; i++) begin
      mask_d[i] = (cfg_we && (cfg_sid == SID_W'(i))) ? cfg_mask : mask_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mask_q[i] <= '1;
      end
    end else begin
      seen_q <= seen_d;
      for (int i = 0; i < DEPTH; i++) begin
        mask_q[i] <= mask_d[i];
      end
    end
  end

endmodule

// File: rtl/dpi_stream_sequencer.sv
// Packet sequencer driving the shared matcher-wrapper bus and collecting one fired record per packet.
// Latency: sop sampled -> LOAD next cycle; LOAD -> res_valid is LOAD_GAP+DRAIN_CYC+2+packet_len cycles.
// Backpressure: in_ready low outside IDLE(non-sop)/STREAM; a stalled result (res_ready low) holds off the next sop.
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset (aborts any packet)
//   in_valid/in_ready/in_data         input byte stream, in_sop/in_eop frame it, in_sid valid on sop
//   cfg_we/cfg_sid/cfg_mask           per-stream regex enable mask write
//   stream_clear                      forget all seen stream ids
//   load_state/new_stream_id/stream_id/char_in/char_in_vld/eop/enable   wrapper bus
//   fired                             wrapper match vector
//   res_valid/res_ready/res_sid/res_fired   per-packet result record
//   pkt_count (wraps), drop_count (saturates)
module dpi_stream_sequencer
  import dpi_seq_pkg::*;
#(
  parameter int NUM_REGEX = NUM_REGEX_DEF,
  parameter int SID_W     = SID_W_DEF,
  parameter int LOAD_GAP  = LOAD_GAP_DEF,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_data,
  input  logic                 in_sop,
  input  logic                 in_eop,
  input  logic [SID_W-1:0]     in_sid,
  input  logic                 cfg_we,
  input  logic [SID_W-1:0]     cfg_sid,
  input  logic [NUM_REGEX-1:0] cfg_mask,
  input  logic                 stream_clear,
  output logic                 load_state,
  output logic                 new_stream_id,
  output logic [SID_W-1:0]     stream_id,
  output logic [7:0]           char_in,
  output logic                 char_in_vld,
  output logic                 eop,
  output logic [NUM_REGEX-1:0] enable,
  input  logic [NUM_REGEX-1:0] fired,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [SID_W-1:0]     res_sid,
  output logic [NUM_REGEX-1:0] res_fired,
  output logic [15:0]          pkt_count,
  output logic [15:0]          drop_count
);

  seq_state_t           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SID_W-1:0]     sid_q, sid_d;
  logic [NUM_REGEX-1:0] enable_q, enable_d;
  logic [SID_W-1:0]     res_sid_q, res_sid_d;
  logic [NUM_REGEX-1:0] res_fired_q, res_fired_d;
  logic [15:0]          pkt_count_q, pkt_count_d;
  logic [15:0]          drop_count_q, drop_count_d;

  logic                 in_ready_c;
  logic                 tbl_seen;
  logic [NUM_REGEX-1:0] tbl_mask;
  logic                 tbl_set_seen;

  dpi_stream_table #(
    .SID_W     (SID_W),
    .NUM_REGEX (NUM_REGEX)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .rd_sid    (sid_q),
    .rd_seen   (tbl_seen),
    .rd_mask   (tbl_mask),
    .set_seen  (tbl_set_seen),
    .clear_all (stream_clear),
    .cfg_we    (cfg_we),
    .cfg_sid   (cfg_sid),
    .cfg_mask  (cfg_mask)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sid_d         = sid_q;
    enable_d      = enable_q;
    res_sid_d     = res_sid_q;
    res_fired_d   = res_fired_q;
    pkt_count_d   = pkt_count_q;
    drop_count_d  = drop_count_q;
    in_ready_c    = 1'b0;
    load_state    = 1'b0;
    new_stream_id = 1'b0;
    char_in       = 8'h00;
    char_in_vld   = 1'b0;
    eop           = 1'b0;
    res_valid     = 1'b0;
    tbl_set_seen  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The sop byte is only peeked here; it is consumed later in STREAM.
        in_ready_c = ~in_sop;
        if (in_valid) begin
          if (in_sop) begin
            sid_d   = in_sid;
            state_d = ST_LOAD;
          end else begin
            drop_count_d = sat_inc16(drop_count_q);
          end
        end
      end

      ST_LOAD: begin
        load_state    = 1'b1;
        // Table read is pre-update, so a clear or cfg write this cycle only affects later packets.
        new_stream_id = ~tbl_seen;
        tbl_set_seen  = 1'b1;
        enable_d      = tbl_mask;
        if (LOAD_GAP == 0) begin
          state_d = ST_STREAM;
        end else begin
          cnt_d   = CNT_W'(LOAD_GAP - 1);
          state_d = ST_GAP;
        end
      end

      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_STREAM;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_STREAM: begin
        in_ready_c  = 1'b1;
        char_in     = in_data;
        char_in_vld = in_valid;
        // A repeated sop mid-packet is just data; only eop ends the stream.
        if (in_valid && in_eop) begin
          if (DRAIN_CYC == 0) begin
            state_d = ST_EOP;
          end else begin
            cnt_d   = CNT_W'(DRAIN_CYC - 1);
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = ST_EOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_EOP: begin
        eop         = 1'b1;
        res_fired_d = fired & enable_q;
        res_sid_d   = sid_q;
        pkt_count_d = pkt_count_q + 16'd1;
        state_d     = ST_RESULT;
      end

      ST_RESULT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sid_q        <= '0;
      enable_q     <= '0;
      res_sid_q    <= '0;
      res_fired_q  <= '0;
      pkt_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sid_q        <= sid_d;
      enable_q     <= enable_d;
      res_sid_q    <= res_sid_d;
      res_fired_q  <= res_fired_d;
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Nothing is accepted while reset is held, even though IDLE would otherwise take non-sop bytes.
  assign in_ready = in_ready_c & ~rst;
  // During LOAD the wrappers see the mask being latched, so enable is valid from the load_state cycle on.
  assign enable     = (state_q == ST_LOAD) ? tbl_mask : enable_q;
  assign stream_id  = sid_q;
  assign res_sid    = res_sid_q;
  assign res_fired  = res_fired_q;
  assign pkt_count  = pkt_count_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
module tb_dpi_stream_sequencer;

  localparam int NR   = 16;
  localparam int SW   = 6;
  localparam int GAP  = 2;
  localparam int DRN  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_data = 8'h00;
  logic          in_sop = 1'b0;
  logic          in_eop = 1'b0;
  logic [SW-1:0] in_sid = '0;
  logic          cfg_we = 1'b0;
  logic [SW-1:0] cfg_sid = '0;
  logic [NR-1:0] cfg_mask = '0;
  logic          stream_clear = 1'b0;
  logic          load_state, new_stream_id, char_in_vld, eop, res_valid;
  logic          res_ready = 1'b0;
  logic [SW-1:0] stream_id, res_sid;
  logic [7:0]    char_in;
  logic [NR-1:0] enable, res_fired, fired_m;
  logic [15:0]   pkt_count, drop_count;
  logic [NR-1:0] cur_pat = '0;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dpi_stream_sequencer #(
    .NUM_REGEX (NR),
    .SID_W     (SW),
    .LOAD_GAP  (GAP),
    .DRAIN_CYC (DRN)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_sop        (in_sop),
    .in_eop        (in_eop),
    .in_sid        (in_sid),
    .cfg_we        (cfg_we),
    .cfg_sid       (cfg_sid),
    .cfg_mask      (cfg_mask),
    .stream_clear  (stream_clear),
    .load_state    (load_state),
    .new_stream_id (new_stream_id),
    .stream_id     (stream_id),
    .char_in       (char_in),
    .char_in_vld   (char_in_vld),
    .eop           (eop),
    .enable        (enable),
    .fired         (fired_m),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_sid       (res_sid),
    .res_fired     (res_fired),
    .pkt_count     (pkt_count),
    .drop_count    (drop_count)
  );

  // Wrapper model: match vector clears on load_state and reports the packet pattern once a char arrives.
  always @(posedge clk or posedge rst) begin
    if (rst)              fired_m <= '0;
    else if (load_state)  fired_m <= '0;
    else if (char_in_vld) fired_m <= cur_pat;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  typedef struct {
    logic [SW-1:0] sid;
    int            len;
    logic [NR-1:0] pat;
    int            cfg_mode;   // 0 none, 1 write before packet, 2 write during LOAD
    logic [NR-1:0] cfg_m;
    int            clr_mode;   // 0 none, 1 clear before packet, 2 clear during LOAD
    logic          exp_new;
    logic [NR-1:0] exp_mask;
    logic [NR-1:0] exp_fired;
    logic [15:0]   exp_pkt;
  } vec_t;

  vec_t vecs [11];

  // Runs one packet starting in IDLE; returns at posedge+1 after the result handshake edge.
  task automatic run_pkt(input vec_t v, input int hold);
    int idx = 0, cyc = 0, rv = 0;
    int loads = 0, eops = 0, chars = 0, orphan = 0, bad_hold = 0, bad_data = 0;
    int bad_steady = 0, bad_rdy = 0;
    int load_cyc = 0, first_c = 0, last_c = 0, eop_cyc = 0, res_cyc = 0;
    logic new_seen = 1'b0, done = 1'b0, in_pkt = 1'b0;
    logic [SW-1:0] rsid = '0;
    logic [NR-1:0] rfired = '0;
    logic [15:0]   rpkt = '0;
    cur_pat = v.pat;
    if (v.cfg_mode == 1) begin cfg_we = 1'b1; cfg_sid = v.sid; cfg_mask = v.cfg_m; end
    if (v.clr_mode == 1) stream_clear = 1'b1;
    if (v.cfg_mode == 1 || v.clr_mode == 1) begin
      @(posedge clk); #1;
      cfg_we = 1'b0; stream_clear = 1'b0;
    end
    while (!done && cyc < 100) begin
      in_valid = (idx < v.len);
      in_sop   = (idx == 0);
      in_eop   = (idx == v.len - 1);
      in_data  = 8'(idx + 48);
      in_sid   = (idx == 0) ? v.sid : ~v.sid;
      if (hold > 0 && idx >= v.len) begin
        in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b0; in_sid = 6'd20;
      end
      res_ready    = (rv >= hold);
      cfg_we       = (v.cfg_mode == 2) && load_state;
      cfg_sid      = v.sid;
      cfg_mask     = v.cfg_m;
      stream_clear = (v.clr_mode == 2) && load_state;
      @(negedge clk);
      if (load_state) begin loads++; load_cyc = cyc; new_seen = new_stream_id; in_pkt = 1'b1; end
      if (new_stream_id && !load_state) orphan++;
      if (in_pkt && (stream_id !== v.sid || enable !== v.exp_mask)) bad_hold++;
      if (char_in_vld) begin
        if (chars == 0) first_c = cyc;
        last_c = cyc;
        if (char_in !== 8'(chars + 48)) bad_data++;
        chars++;
      end
      if (eop) begin eops++; eop_cyc = cyc; in_pkt = 1'b0; end
      if (res_valid) begin
        if (rv == 0) begin
          res_cyc = cyc; rsid = res_sid; rfired = res_fired; rpkt = pkt_count;
        end else if (res_sid !== rsid || res_fired !== rfired) begin
          bad_steady++;
        end
        if (hold > 0 && in_valid && in_ready) bad_rdy++;
        rv++;
        if (res_ready) done = 1'b1;
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    cfg_we = 1'b0; stream_clear = 1'b0; res_ready = 1'b0;
    if (hold == 0) begin in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; end
    chk("pkt_done", 32'(done), 32'd1);
    chk("load_pulses", 32'(loads), 32'd1);
    chk("new_stream_id", 32'(new_seen), 32'(v.exp_new));
    chk("new_without_load", 32'(orphan), 32'd0);
    chk("char_vld_count", 32'(chars), 32'(v.len));
    chk("char_data", 32'(bad_data), 32'd0);
    chk("eop_pulses", 32'(eops), 32'd1);
    chk("load_to_first_char", 32'(first_c - load_cyc), 32'(GAP + 1));
    chk("last_char_to_eop", 32'(eop_cyc - last_c), 32'(DRN + 1));
    chk("load_to_res_valid", 32'(res_cyc - load_cyc), 32'(GAP + DRN + 2 + v.len));
    chk("sid_enable_held", 32'(bad_hold), 32'd0);
    chk("res_sid", 32'(rsid), 32'(v.sid));
    chk("res_fired", 32'(rfired), 32'(v.exp_fired));
    chk("pkt_count", 32'(rpkt), 32'(v.exp_pkt));
    if (hold > 0) begin
      chk("res_valid_cycles", 32'(rv), 32'(hold + 1));
      chk("res_steady", 32'(bad_steady), 32'd0);
      chk("in_ready_in_result", 32'(bad_rdy), 32'd0);
    end
  endtask

  initial begin
    int   eops;
    int   loads;
    logic found;
    vec_t hv;

    //           sid    len pat        cfg cfg_m     clr new   mask       fired      pkt
    vecs[0]  = '{6'd5,  3, 16'hFFFF,  0, 16'h0000, 0, 1'b1, 16'hFFFF, 16'hFFFF, 16'd1};
    vecs[1]  = '{6'd5,  3, 16'hFFFF,  0, 16'h0000, 0, 1'b0, 16'hFFFF, 16'hFFFF, 16'd2};
    vecs[2]  = '{6'd5,  2, 16'hFFFF,  0, 16'h0000, 1, 1'b1, 16'hFFFF, 16'hFFFF, 16'd3};
    vecs[3]  = '{6'd7,  4, 16'hFFFF,  1, 16'h0001, 0, 1'b1, 16'h0001, 16'h0001, 16'd4};
    vecs[4]  = '{6'd63, 1, 16'hA5A5,  0, 16'h0000, 0, 1'b1, 16'hFFFF, 16'hA5A5, 16'd5};
    vecs[5]  = '{6'd9,  2, 16'h3C3C,  2, 16'h0FF0, 0, 1'b1, 16'hFFFF, 16'h3C3C, 16'd6};
    vecs[6]  = '{6'd9,  1, 16'h3C3C,  0, 16'h0000, 0, 1'b0, 16'h0FF0, 16'h0C30, 16'd7};
    vecs[7]  = '{6'd9,  2, 16'hFFFF,  0, 16'h0000, 2, 1'b0, 16'h0FF0, 16'h0FF0, 16'd8};
    vecs[8]  = '{6'd9,  1, 16'hFFFF,  0, 16'h0000, 0, 1'b0, 16'h0FF0, 16'h0FF0, 16'd9};
    vecs[9]  = '{6'd5,  1, 16'hFFFF,  0, 16'h0000, 0, 1'b1, 16'hFFFF, 16'hFFFF, 16'd10};
    vecs[10] = '{6'd7,  2, 16'h00FF,  0, 16'h0000, 0, 1'b1, 16'h0001, 16'h0001, 16'd11};

    // Reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_load_state", 32'(load_state), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_enable", 32'(enable), 32'd0);
    chk("rst_counts", {pkt_count, drop_count}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Non-sop bytes in IDLE are dropped and counted
    loads = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_sop = 1'b0; in_data = 8'(8'hA0 + i);
      @(negedge clk);
      chk("idle_drop_ready", 32'(in_ready), 32'd1);
      if (load_state) loads++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    if (load_state) loads++;
    chk("drop_no_load", 32'(loads), 32'd0);
    chk("drop_count", 32'(drop_count), 32'd2);
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) run_pkt(vecs[i], 0);
    chk("drop_count_stable", 32'(drop_count), 32'd2);

    // Result stalled 10 cycles with the next sop waiting
    hv = '{6'd12, 2, 16'hFFFF, 0, 16'h0000, 0, 1'b1, 16'hFFFF, 16'hFFFF, 16'd12};
    run_pkt(hv, 10);
    @(negedge clk);
    chk("idle_after_handshake", 32'(load_state), 32'd0);
    chk("idle_sop_not_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("load_after_handshake", 32'(load_state), 32'd1);
    chk("pending_new_stream", 32'(new_stream_id), 32'd1);
    chk("pending_stream_id", 32'(stream_id), 32'd20);
    @(posedge clk); #1;
    in_sop = 1'b0; in_data = 8'h77;

    // Reset in STREAM aborts the packet
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (char_in_vld) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("stream_reached", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_char_vld", 32'(char_in_vld), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_stream_id", 32'(stream_id), 32'd0);
    chk("arst_enable", 32'(enable), 32'd0);
    chk("arst_pkt_count", 32'(pkt_count), 32'd0);
    in_valid = 1'b0;
    eops = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i == 2) rst = 1'b0;
      @(negedge clk);
      if (eop) eops++;
    end
    @(posedge clk); #1;
    chk("no_eop_after_abort", 32'(eops), 32'd0);
    hv = '{6'd5, 2, 16'hFFFF, 0, 16'h0000, 0, 1'b1, 16'hFFFF, 16'hFFFF, 16'd1};
    run_pkt(hv, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
